sd_cmd_serial_host: RTL and testbench



---
 rtl/sd_cmd_pkg.sv | 29 ++
 rtl/sd_crc7.sv | 35 +++
 rtl/sd_cmd_serial_host.sv | 245 ++++++++++++++++++++++++
 tb/tb_sd_cmd_serial_host.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD CMD-line serial engine.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX,
        TURN,
        WAIT_START,
        RX,
        FINISH,
        NCC
    } sd_cmd_state_e;

    localparam int SD_CMD_TX_BITS    = 48;
    localparam int SD_CMD_SHORT_BITS = 48;
    localparam int SD_CMD_LONG_BITS  = 136;
    localparam int SD_CMD_NCR_MIN    = 2;
    localparam int SD_CMD_NCC        = 8;

    // x^7 + x^3 + 1 with the x^7 term implicit
    localparam logic [6:0] SD_CMD_CRC7_POLY = 7'h09;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? SD_CMD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator: clear has priority over enable, one bit per enabled cycle.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clock,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = crc7_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_serial_host.sv
// Bit-serial SD CMD-line engine: sends a 48-bit command token, captures a 48/136-bit response.
// Optional SD_CMD_NCC_WAIT_EN adds an 8-enable NCC hold-off after FINISH.
module sd_cmd_serial_host
    import sd_cmd_pkg::*;
(
    input  logic         clock,
    input  logic         rst,
    input  logic         clock_posedge,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [1:0]   setting_i,
    input  logic [39:0]  cmd_i,
    input  logic         cmd_dat_i,
    output logic         cmd_out_o,
    output logic         cmd_oe_o,
    output logic [119:0] response_o,
    output logic         crc_ok_o,
    output logic         index_ok_o,
    output logic         finish_o
);

    localparam logic [7:0] TX_CRC_START = 8'(SD_CMD_TX_BITS - 8);
    localparam logic [7:0] TX_END_BIT   = 8'(SD_CMD_TX_BITS - 1);
    localparam logic [7:0] TX_DONE      = 8'(SD_CMD_TX_BITS);

    sd_cmd_state_e state_q, state_d;
    logic [7:0]    bit_cnt_q, bit_cnt_d;
    logic [39:0]   cmd_q, cmd_d;
    logic [1:0]    set_q, set_d;
    logic          cmd_out_q, cmd_out_d;
    logic          cmd_oe_q, cmd_oe_d;
    logic [119:0]  resp_shift_q, resp_shift_d;
    logic [5:0]    idx_rx_q, idx_rx_d;
    logic [6:0]    crc_rx_q, crc_rx_d;
    logic [119:0]  response_q, response_d;
    logic          crc_ok_q, crc_ok_d;
    logic          index_ok_q, index_ok_d;
    logic          finish_q, finish_d;

    logic          tx_crc_en, tx_crc_clr, tx_crc_bit;
    logic          rx_crc_en, rx_crc_clr, rx_crc_bit;
    logic [6:0]    tx_crc, rx_crc;

    logic          rx_long;
    logic [7:0]    rx_crc_lo;
    logic [7:0]    rx_last;
    logic [5:0]    tx_idx;
    logic [2:0]    tx_crc_sel;

    assign rx_long    = set_q[1];
    assign rx_crc_lo  = rx_long ? 8'(SD_CMD_LONG_BITS - 8) : 8'(SD_CMD_SHORT_BITS - 8);
    assign rx_last    = rx_long ? 8'(SD_CMD_LONG_BITS - 1) : 8'(SD_CMD_SHORT_BITS - 1);
    assign tx_idx     = 6'(8'd39 - bit_cnt_q);
    assign tx_crc_sel = 3'(8'd46 - bit_cnt_q);

    sd_crc7 u_tx_crc (
        .clock (clock),
        .rst   (rst),
        .en    (tx_crc_en),
        .clr   (tx_crc_clr),
        .bit_i (tx_crc_bit),
        .crc_o (tx_crc)
    );

    sd_crc7 u_rx_crc (
        .clock (clock),
        .rst   (rst),
        .en    (rx_crc_en),
        .clr   (rx_crc_clr),
        .bit_i (rx_crc_bit),
        .crc_o (rx_crc)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        cmd_d        = cmd_q;
        set_d        = set_q;
        cmd_out_d    = cmd_out_q;
        cmd_oe_d     = cmd_oe_q;
        resp_shift_d = resp_shift_q;
        idx_rx_d     = idx_rx_q;
        crc_rx_d     = crc_rx_q;
        response_d   = response_q;
        crc_ok_d     = crc_ok_q;
        index_ok_d   = index_ok_q;
        finish_d     = finish_q;
        tx_crc_en    = 1'b0;
        tx_crc_clr   = 1'b0;
        tx_crc_bit   = 1'b0;
        rx_crc_en    = 1'b0;
        rx_crc_clr   = 1'b0;
        rx_crc_bit   = cmd_dat_i;

        if (clock_posedge) begin
            if (abort_i) begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                cmd_oe_d  = 1'b0;
                cmd_out_d = 1'b1;
                finish_d  = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cmd_oe_d  = 1'b0;
                        cmd_out_d = 1'b1;
                        if (start_i) begin
                            cmd_d      = cmd_i;
                            set_d      = setting_i;
                            tx_crc_clr = 1'b1;
                            rx_crc_clr = 1'b1;
                            crc_ok_d   = 1'b0;
                            index_ok_d = 1'b0;
                            bit_cnt_d  = '0;
                            state_d    = TX;
                        end
                    end
                    TX: begin
                        cmd_oe_d  = 1'b1;
                        bit_cnt_d = bit_cnt_q + 8'd1;
                        if (bit_cnt_q < TX_CRC_START) begin
                            cmd_out_d  = cmd_q[tx_idx];
                            tx_crc_en  = 1'b1;
                            tx_crc_bit = cmd_q[tx_idx];
                        end else if (bit_cnt_q < TX_END_BIT) begin
                            cmd_out_d = tx_crc[tx_crc_sel];
                        end else if (bit_cnt_q == TX_END_BIT) begin
                            cmd_out_d = 1'b1;
                        end else begin
                            cmd_oe_d  = 1'b0;
                            cmd_out_d = 1'b1;
                            if (set_q[0]) begin
                                // the line sample taken here is the first ignored Ncr sample
                                bit_cnt_d = 8'd1;
                                state_d   = TURN;
                            end else begin
                                finish_d = 1'b1;
                                state_d  = FINISH;
                            end
                        end
                    end
                    TURN: begin
                        if (bit_cnt_q >= 8'(SD_CMD_NCR_MIN - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = WAIT_START;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 8'd1;
                        end
                    end
                    WAIT_START: begin
                        if (!cmd_dat_i) begin
                            rx_crc_en = 1'b1;
                            bit_cnt_d = 8'd1;
                            state_d   = RX;
                        end
                    end
                    RX: begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                        if (bit_cnt_q >= 8'd2 && bit_cnt_q < 8'd8) begin
                            idx_rx_d = {idx_rx_q[4:0], cmd_dat_i};
                        end
                        if (bit_cnt_q < rx_crc_lo && (!rx_long || bit_cnt_q >= 8'd8)) begin
                            rx_crc_en = 1'b1;
                        end
                        if (bit_cnt_q >= 8'd8 && bit_cnt_q < rx_crc_lo) begin
                            resp_shift_d = {resp_shift_q[118:0], cmd_dat_i};
                        end
                        if (bit_cnt_q >= rx_crc_lo && bit_cnt_q < rx_last) begin
                            crc_rx_d = {crc_rx_q[5:0], cmd_dat_i};
                        end
                        if (bit_cnt_q == rx_last) begin
                            response_d = rx_long ? resp_shift_q : {resp_shift_q[31:0], 88'd0};
                            crc_ok_d   = (rx_crc == crc_rx_q);
                            index_ok_d = rx_long ? (idx_rx_q == 6'h3F) : (idx_rx_q == cmd_q[37:32]);
                            finish_d   = 1'b1;
                            state_d    = FINISH;
                        end
                    end
                    FINISH: begin
                        finish_d  = 1'b0;
                        bit_cnt_d = '0;
`ifdef SD_CMD_NCC_WAIT_EN
                        state_d   = NCC;
`else
                        state_d   = IDLE;
`endif
                    end
                    NCC: begin
                        if (bit_cnt_q == 8'(SD_CMD_NCC - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_d   = IDLE;
                        cmd_oe_d  = 1'b0;
                        cmd_out_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            cmd_q        <= '0;
            set_q        <= '0;
            cmd_out_q    <= 1'b1;
            cmd_oe_q     <= 1'b0;
            resp_shift_q <= '0;
            idx_rx_q     <= '0;
            crc_rx_q     <= '0;
            response_q   <= '0;
            crc_ok_q     <= 1'b0;
            index_ok_q   <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            cmd_q        <= cmd_d;
            set_q        <= set_d;
            cmd_out_q    <= cmd_out_d;
            cmd_oe_q     <= cmd_oe_d;
            resp_shift_q <= resp_shift_d;
            idx_rx_q     <= idx_rx_d;
            crc_rx_q     <= crc_rx_d;
            response_q   <= response_d;
            crc_ok_q     <= crc_ok_d;
            index_ok_q   <= index_ok_d;
            finish_q     <= finish_d;
        end
    end

    assign cmd_out_o  = cmd_out_q;
    assign cmd_oe_o   = cmd_oe_q;
    assign response_o = response_q;
    assign crc_ok_o   = crc_ok_q;
    assign index_ok_o = index_ok_q;
    assign finish_o   = finish_q;

endmodule

// File: tb/tb_sd_cmd_serial_host.sv
// Self-checking bench for sd_cmd_serial_host: vector table plus hand-written corner sequences.
module tb_sd_cmd_serial_host;

    logic         clock;
    logic         rst;
    logic         clock_posedge;
    logic         start_i;
    logic         abort_i;
    logic [1:0]   setting_i;
    logic [39:0]  cmd_i;
    logic         cmd_dat_i;
    logic         cmd_out_o;
    logic         cmd_oe_o;
    logic [119:0] response_o;
    logic         crc_ok_o;
    logic         index_ok_o;
    logic         finish_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [119:0] resp;
        logic         crc_ok;
        logic         idx_ok;
    } exp_t;

    exp_t         sb_q[$];
    logic [119:0] last_resp;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [1:0]  setting;
        logic [47:0] token;
        logic [47:0] reply;
        int          delay;
        bit          turn_low;
        logic [31:0] exp_pay;
        logic        exp_crc;
        logic        exp_idx;
    } vec_t;

    vec_t vecs[6];

    sd_cmd_serial_host dut (
        .clock         (clock),
        .rst           (rst),
        .clock_posedge (clock_posedge),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .setting_i     (setting_i),
        .cmd_i         (cmd_i),
        .cmd_dat_i     (cmd_dat_i),
        .cmd_out_o     (cmd_out_o),
        .cmd_oe_o      (cmd_oe_o),
        .response_o    (response_o),
        .crc_ok_o      (crc_ok_o),
        .index_ok_o    (index_ok_o),
        .finish_o      (finish_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // SD-clock enable on every other system clock
    initial begin
        clock_posedge = 1'b0;
        forever begin
            @(negedge clock);
            clock_posedge = ~clock_posedge;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_short(input logic [7:0] head, input logic [31:0] pay);
        logic [39:0] b;
        b = {head, pay};
        return {b, crc7(120'(b), 40), 1'b1};
    endfunction

    task automatic tick();
        do @(posedge clock); while (clock_posedge !== 1'b1);
        #1;
    endtask

    task automatic chk(input string name, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic settle();
`ifdef SD_CMD_NCC_WAIT_EN
        repeat (9) tick();
`endif
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                            input logic [1:0] setting, input logic [47:0] token);
        logic [47:0] got;
        int          oe_cnt;
        int          fin_cnt;
        oe_cnt    = 0;
        fin_cnt   = 0;
        cmd_i     = {2'b01, idx, arg};
        setting_i = setting;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        for (int k = 0; k < 48; k++) begin
            tick();
            got[47 - k] = cmd_out_o;
            oe_cnt  += int'(cmd_oe_o);
            fin_cnt += int'(finish_o);
        end
        chk("tx_token", 136'(got), 136'(token));
        chk("tx_oe_cycles", 136'(oe_cnt), 136'(48));
        chk("tx_no_finish", 136'(fin_cnt), 136'(0));
    endtask

    // called just after the enable edge where finish_o must rise
    task automatic end_check();
        exp_t e;
        chk("finish_rise", 136'(finish_o), 136'(1));
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow got=finish exp=none");
        end else begin
            e = sb_q.pop_front();
            chk("response", 136'(response_o), 136'(e.resp));
            chk("crc_ok", 136'(crc_ok_o), 136'(e.crc_ok));
            chk("index_ok", 136'(index_ok_o), 136'(e.idx_ok));
        end
        cmd_dat_i = 1'b1;
        tick();
        chk("finish_fall", 136'(finish_o), 136'(0));
    endtask

    task automatic recv(input logic [135:0] frame, input int nbits, input int delay, input bit turn_low);
        int fin;
        int oe;
        fin = 0;
        oe  = 0;
        cmd_dat_i = turn_low ? 1'b0 : 1'b1;
        tick();
        chk("oe_drop", 136'(cmd_oe_o), 136'(0));
        tick();
        cmd_dat_i = 1'b1;
        repeat (delay) begin
            tick();
            fin += int'(finish_o);
        end
        for (int j = 0; j < nbits; j++) begin
            cmd_dat_i = frame[nbits - 1 - j];
            tick();
            oe += int'(cmd_oe_o);
            if (j < nbits - 1) fin += int'(finish_o);
        end
        chk("rx_early_finish", 136'(fin), 136'(0));
        chk("rx_oe_low", 136'(oe), 136'(0));
        end_check();
    endtask

    initial begin
        logic [119:0] cid;
        logic [135:0] r2;
        logic [39:0]  c2;
        int           fin;

        rst       = 1'b1;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        setting_i = 2'b00;
        cmd_i     = '0;
        cmd_dat_i = 1'b1;
        last_resp = '0;

        vecs[0] = '{6'd0,  32'h0000_0000, 2'b00, 48'h40_0000_0000_95, 48'h0,
                    0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{6'd8,  32'h0000_01AA, 2'b01, 48'h48_0000_01AA_87, 48'h08_0000_01AA_13,
                    0, 1'b0, 32'h0000_01AA, 1'b1, 1'b1};
        vecs[2] = '{6'd8,  32'h0000_01AA, 2'b01, 48'h48_0000_01AA_87, 48'h08_0000_01AB_13,
                    5, 1'b0, 32'h0000_01AB, 1'b0, 1'b1};
        vecs[3] = '{6'd8,  32'h0000_01AA, 2'b01, 48'h48_0000_01AA_87, mk_short(8'h09, 32'h0000_01AA),
                    2, 1'b0, 32'h0000_01AA, 1'b1, 1'b0};
        vecs[4] = '{6'd55, 32'h0000_0000, 2'b01, 48'h77_0000_0000_65, mk_short(8'h37, 32'h0000_0120),
                    1, 1'b1, 32'h0000_0120, 1'b1, 1'b1};
        vecs[5] = '{6'd41, 32'h4000_0000, 2'b01, 48'h69_4000_0000_77, {8'h3F, 32'h80FF_8000, 8'hFF},
                    7, 1'b0, 32'h80FF_8000,
                    (crc7(120'({8'h3F, 32'h80FF_8000}), 40) == 7'h7F), 1'b0};

        repeat (4) @(posedge clock);
        #1;
        rst = 1'b0;
        chk("rst_cmd_out", 136'(cmd_out_o), 136'(1));
        chk("rst_cmd_oe", 136'(cmd_oe_o), 136'(0));
        chk("rst_response", 136'(response_o), 136'(0));
        chk("rst_crc_ok", 136'(crc_ok_o), 136'(0));
        chk("rst_index_ok", 136'(index_ok_o), 136'(0));
        chk("rst_finish", 136'(finish_o), 136'(0));
        tick();

        for (int v = 0; v < 6; v++) begin
            if (!vecs[v].setting[0]) begin
                sb_q.push_back('{last_resp, 1'b0, 1'b0});
            end else begin
                sb_q.push_back('{{vecs[v].exp_pay, 88'd0}, vecs[v].exp_crc, vecs[v].exp_idx});
            end
            send_cmd(vecs[v].idx, vecs[v].arg, vecs[v].setting, vecs[v].token);
            if (!vecs[v].setting[0]) begin
                tick();
                chk("oe_drop", 136'(cmd_oe_o), 136'(0));
                end_check();
            end else begin
                recv(136'(vecs[v].reply), 48, vecs[v].delay, vecs[v].turn_low);
                last_resp = {vecs[v].exp_pay, 88'd0};
            end
            settle();
        end

        // long R2 response
        cid = 120'h1D4144534420202010A0400BC10088;
        r2  = {8'h3F, cid, crc7(cid, 120), 1'b1};
        c2  = {2'b01, 6'd2, 32'h0};
        sb_q.push_back('{cid, 1'b1, 1'b1});
        send_cmd(6'd2, 32'h0, 2'b11, {c2, crc7(120'(c2), 40), 1'b1});
        recv(r2, 136, 3, 1'b0);
        last_resp = cid;
        settle();

        // no reply for 500 enables, then abort
        send_cmd(6'd8, 32'h0000_01AA, 2'b01, 48'h48_0000_01AA_87);
        cmd_dat_i = 1'b1;
        fin = 0;
        repeat (502) begin
            tick();
            fin += int'(finish_o);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_oe", 136'(cmd_oe_o), 136'(0));
        chk("abort_out", 136'(cmd_out_o), 136'(1));
        chk("abort_no_finish", 136'(fin + int'(finish_o)), 136'(0));
        tick();
        sb_q.push_back('{last_resp, 1'b0, 1'b0});
        send_cmd(6'd0, 32'h0, 2'b00, 48'h40_0000_0000_95);
        tick();
        end_check();

        // back-to-back start right after FINISH
`ifdef SD_CMD_NCC_WAIT_EN
        cmd_i   = {2'b01, 6'd55, 32'h0};
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        chk("ncc_start_ignored", 136'(cmd_oe_o), 136'(0));
        repeat (9) tick();
`else
        sb_q.push_back('{last_resp, 1'b0, 1'b0});
        send_cmd(6'd55, 32'h0, 2'b00, 48'h77_0000_0000_65);
        tick();
        end_check();
`endif

        // synchronous reset in the middle of TX
        cmd_i     = {2'b01, 6'd17, 32'h0000_1234};
        setting_i = 2'b01;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        repeat (21) tick();
        chk("midtx_oe", 136'(cmd_oe_o), 136'(1));
        rst = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_midtx_oe", 136'(cmd_oe_o), 136'(0));
        chk("rst_midtx_out", 136'(cmd_out_o), 136'(1));
        chk("rst_midtx_resp", 136'(response_o), 136'(0));
        rst = 1'b0;
        last_resp = '0;
        tick();

        // abort wins over start
        cmd_i   = {2'b01, 6'd0, 32'h0};
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        tick();
        chk("start_abort_oe", 136'(cmd_oe_o), 136'(0));
        tick();
        chk("start_abort_out", 136'(cmd_out_o), 136'(1));

        sb_q.push_back('{last_resp, 1'b0, 1'b0});
        send_cmd(6'd0, 32'h0, 2'b00, 48'h40_0000_0000_95);
        tick();
        end_check();

        chk("sb_empty", 136'(sb_q.size()), 136'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
